cond_unit: RTL

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/arm_pkg.sv | 28 ++
 rtl/cond_eval.sv | 44 ++++
 rtl/cond_unit.sv | 71 +++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM condition-code encodings and flag bit positions used by the
// condition unit and its decode sub-module.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Flags are packed {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition decode: maps the 4-bit cond field and the current
// {N,Z,C,V} flags to a single execute decision.
module cond_eval
  import arm_pkg::*;
#(
  parameter bit RESERVED_EXEC = 1'b0
) (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       result
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    result = 1'b0;
    case (Cond)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = ge;
      COND_LT: result = ~ge;
      COND_GT: result = ~z & ge;
      COND_LE: result = z | ~ge;
      COND_AL: result = 1'b1;
      COND_NV: result = RESERVED_EXEC;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural flags and the captured
// execute decision, and gates the datapath write enables with it.
module cond_unit
  import arm_pkg::*;
#(
  parameter bit RESERVED_EXEC = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       CondCapture,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_result;

  cond_eval #(
    .RESERVED_EXEC(RESERVED_EXEC)
  ) u_cond_eval (
    .Cond  (Cond),
    .Flags (flags_q),
    .result(cond_result)
  );

  // Flag writes are gated by the decision already held, never the one being captured.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (FlagW[1] && cond_ex_q) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
    if (CondCapture) begin
      cond_ex_d = cond_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign Flags    = flags_q;
  assign CondEx   = cond_ex_q;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  // Sequential PC increments bypass the condition so fetch never stalls.
  assign PCWrite  = (PCS & cond_ex_q) | NextPC;

endmodule
